// File: rtl/fpa_arb_pkg.sv
// Shared types for the FPA arbiter: the operand word and the arbiter FSM states.
package fpa_arb_pkg;

    localparam int FP_W = 32;

    typedef logic [FP_W-1:0] fp32_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/fpa_arbiter_rr_pick.sv
// Combinational round-robin picker: the first asserted req at or after ptr wins,
// wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    logic [ID_W-1:0] w_cand;

    always_comb begin
        gnt    = '0;
        idx    = '0;
        any    = 1'b0;
        w_cand = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = ID_W'((int'(ptr) + k) % NREQ);
            if (!any && req[w_cand]) begin
                any         = 1'b1;
                gnt[w_cand] = 1'b1;
                idx         = w_cand;
            end
        end
    end

endmodule

// File: rtl/fpa_arbiter.sv
// Round-robin arbiter sharing one external combinational FP32 adder among NREQ requesters.
// Optional macro FPA_ARB_OPCNT_EN adds op_count, a count of response handshakes.
module fpa_arbiter
    import fpa_arb_pkg::*;
#(
    parameter int  NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*FP_W-1:0] req_a,
    input  logic [NREQ*FP_W-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output fp32_t                rsp_sum,
    output logic [ID_W-1:0]      rsp_id,
    output fp32_t                fpa_a,
    output fp32_t                fpa_b,
    input  fp32_t                fpa_s
`ifdef FPA_ARB_OPCNT_EN
    ,
    output logic [31:0]          op_count
`endif
);

    arb_state_t      r_state;
    arb_state_t      w_nextState;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] r_idQ;

    logic [NREQ-1:0] w_gnt;
    logic [ID_W-1:0] w_idx;
    logic            w_any;
    logic            w_window;
    logic            w_accept;
    logic            w_rspHandshake;

    fp32_t w_opA [NREQ];
    fp32_t w_opB [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_opA[g] = req_a[g*FP_W +: FP_W];
        assign w_opB[g] = req_b[g*FP_W +: FP_W];
    end

    rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req  (req_valid),
        .ptr  (r_ptr),
        .gnt  (w_gnt),
        .idx  (w_idx),
        .any  (w_any)
    );

    // A new request may enter while idle, or in the same cycle the held result drains.
    always_comb begin
        rsp_valid      = (r_state == RESP);
        w_rspHandshake = rsp_valid && rsp_ready;
        w_window       = (r_state == IDLE) || w_rspHandshake;
        w_accept       = w_window && w_any;
        req_ready      = w_window ? w_gnt : '0;
        w_nextState    = r_state;
        case (r_state)
            IDLE: if (w_accept) w_nextState = EXEC;
            EXEC: w_nextState = RESP;
            RESP: begin
                if (w_accept)            w_nextState = EXEC;
                else if (w_rspHandshake) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_idQ   <= '0;
            fpa_a   <= '0;
            fpa_b   <= '0;
            rsp_sum <= '0;
            rsp_id  <= '0;
        end else begin
            if (w_accept) begin
                fpa_a <= w_opA[w_idx];
                fpa_b <= w_opB[w_idx];
                r_idQ <= w_idx;
                r_ptr <= (w_idx == ID_W'(NREQ-1)) ? '0 : w_idx + 1'b1;
            end
            // The adder settles during EXEC; its output is frozen here for the consumer.
            if (r_state == EXEC) begin
                rsp_sum <= fpa_s;
                rsp_id  <= r_idQ;
            end
        end
    end

`ifdef FPA_ARB_OPCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              op_count <= '0;
        else if (w_rspHandshake) op_count <= op_count + 32'd1;
    end
`endif

    a_gntOneHot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));

    a_rspHold: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid && !rsp_ready |=> rsp_valid && $stable(rsp_sum) && $stable(rsp_id));

endmodule
